pipe_latch_chain: RTL

//  Parametrised elastic pipeline register: DEPTH back-to-back stages of WIDTH-bit data, each with a valid bit.

---
 rtl/pipe_latch_chain_pkg.sv | 10 +
 rtl/pipe_latch_chain_stage.sv | 49 ++++
 rtl/pipe_latch_chain.sv | 91 +++++++++
 3 files changed

// File: rtl/pipe_latch_chain_pkg.sv
// Shared helpers for the elastic pipeline register chain.
// Only sizing arithmetic lives here; the block-specific constants stay local to the top.
package pipe_latch_chain_pkg;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_latch_chain_stage.sv
// One elastic pipeline slot: a data register plus its valid bit.
// The slot has a load enable, a synchronous flush and an asynchronous clear.
module pipe_latch_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    // NOTE: hold values are assigned first so every path drives every output and no latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = RESET_VAL;
    end else if (en_i) begin
      valid_d = valid_i;
      // An incoming bubble leaves the old payload in place, saving toggles on the wide data path.
      if (valid_i) data_d = data_i;
    end
  end

  // NOTE: the clear sits in the sensitivity list, so it acts without waiting for a clock edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      // NOTE: non-blocking updates let every stage sample the pre-edge value of its neighbour.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_latch_chain.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble compression,
// synchronous flush, asynchronous clear and a registered occupancy count.
module pipe_latch_chain
  import pipe_latch_chain_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  localparam logic [WIDTH-1:0] RST_WORD = RESET_VAL;

  if (DEPTH < 1 || WIDTH < 1) begin : g_param_check
    $error("pipe_latch_chain: DEPTH and WIDTH must both be at least 1");
  end

  logic [DEPTH-1:0]            stage_valid;
  logic [DEPTH-1:0][WIDTH-1:0] stage_data;
  logic [DEPTH-1:0]            rdy;
  logic                        in_xfer, out_xfer;
  logic [OCC_W-1:0]            occ_q, occ_d;

  // A stage may load when it is empty or when everything downstream can move this cycle.
  always_comb begin
    rdy          = '0;
    rdy[DEPTH-1] = ~stage_valid[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      rdy[i] = ~stage_valid[i] | rdy[i+1];
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = stage_valid[DEPTH-1] & ~flush;
  assign out_data  = stage_data[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] d_in;

    if (i == 0) begin : g_head
      assign v_in = in_xfer;
      assign d_in = in_data;
    end else begin : g_body
      assign v_in = stage_valid[i-1];
      assign d_in = stage_data[i-1];
    end

    pipe_latch_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RST_WORD)
    ) u_stage (
      .clk     (clk),
      .clr     (clr),
      .flush_i (flush),
      .en_i    (rdy[i]),
      .valid_i (v_in),
      .data_i  (d_in),
      .valid_o (stage_valid[i]),
      .data_o  (stage_data[i])
    );
  end

  // Counting transfers keeps the count registered instead of a popcount over the valid bits.
  always_comb begin
    occ_d = occ_q;
    if (flush) occ_d = '0;
    else       occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule
